// File: rtl/btn_pkg.sv
// Shared encodings and default timings for the button event decoder.
// Imported by button_event and hold_timer.
package btn_pkg;

  typedef enum logic [1:0] {
    ARM     = 2'd0,
    IDLE    = 2'd1,
    PRESSED = 2'd2,
    REPEAT  = 2'd3
  } state_t;

  localparam int DEF_LONG_CYCLES   = 8;
  localparam int DEF_REPEAT_CYCLES = 4;
  localparam int DEF_CNT_W         = 16;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Saturating hold counter; hit flags that the next counted edge
// reaches the threshold.
module hold_timer
  import btn_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] threshold,
  output logic             hit
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt < threshold)) begin
      cnt <= cnt + ONE;
    end
  end

  // True once the saturated count sits at threshold, too.
  assign hit = (cnt >= (threshold - ONE));

endmodule

// File: rtl/button_event.sv
// Turns a debounced button level into press/release/click/long/repeat
// pulses with registered outputs.
module button_event
  import btn_pkg::*;
#(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic repeat_en,
  output logic press_p,
  output logic release_p,
  output logic click_p,
  output logic long_p,
  output logic rpt_p,
  output logic held
);

  localparam int MAXC = max2(LONG_CYCLES, REPEAT_CYCLES);

  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("LONG_CYCLES must be at least 2");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_rpt
    $error("REPEAT_CYCLES must be at least 1");
  end
  if (CNT_W < 1 || (CNT_W < 31 && (1 << CNT_W) <= MAXC)) begin : g_bad_w
    $error("CNT_W too small for the configured thresholds");
  end

  localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] RPT_T  = CNT_W'(REPEAT_CYCLES);

  state_t           state, state_n;
  logic             press_n, release_n, click_n;
  logic             long_n, rpt_n;
  logic             clr, en, hit;
  logic [CNT_W-1:0] thr;

  hold_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .en       (en),
    .threshold(thr),
    .hit      (hit)
  );

  always_comb begin
    state_n   = state;
    press_n   = 1'b0;
    release_n = 1'b0;
    click_n   = 1'b0;
    long_n    = 1'b0;
    rpt_n     = 1'b0;
    clr       = 1'b0;
    en        = 1'b0;
    thr       = LONG_T;
    unique case (state)
      ARM: begin
        clr = 1'b1;
        if (!btn) state_n = IDLE;
      end
      IDLE: begin
        // Counting the press edge itself loads the counter with 1.
        en = btn;
        if (btn) begin
          state_n = PRESSED;
          press_n = 1'b1;
        end
      end
      PRESSED: begin
        if (!btn) begin
          clr       = 1'b1;
          release_n = 1'b1;
          click_n   = 1'b1;
          state_n   = IDLE;
        end else if (hit) begin
          clr     = 1'b1;
          long_n  = 1'b1;
          state_n = REPEAT;
        end else begin
          en = 1'b1;
        end
      end
      REPEAT: begin
        thr = RPT_T;
        if (!btn) begin
          clr       = 1'b1;
          release_n = 1'b1;
          state_n   = IDLE;
        end else if (hit && repeat_en) begin
          clr   = 1'b1;
          rpt_n = 1'b1;
        end else begin
          en = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARM;
      press_p   <= 1'b0;
      release_p <= 1'b0;
      click_p   <= 1'b0;
      long_p    <= 1'b0;
      rpt_p     <= 1'b0;
      held      <= 1'b0;
    end else begin
      state     <= state_n;
      press_p   <= press_n;
      release_p <= release_n;
      click_p   <= click_n;
      long_p    <= long_n;
      rpt_p     <= rpt_n;
      held      <= (state_n == PRESSED) || (state_n == REPEAT);
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event: a hold-length reference model
// queues expected pulses, a monitor compares after every edge.
module tb_button_event;

  localparam int LONG = 8;
  localparam int RPT  = 4;

  logic clk = 1'b0;
  logic rst_n, btn, repeat_en;
  logic press_p, release_p, click_p, long_p, rpt_p, held;

  button_event #(
    .LONG_CYCLES  (LONG),
    .REPEAT_CYCLES(RPT),
    .CNT_W        (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .repeat_en(repeat_en),
    .press_p  (press_p),
    .release_p(release_p),
    .click_p  (click_p),
    .long_p   (long_p),
    .rpt_p    (rpt_p),
    .held     (held)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_no = 0;
  logic [5:0] expq[$];

  bit armed = 1'b0;
  bit pressed = 1'b0;
  bit long_done = 1'b0;
  int hold_len = 0;
  int since = 0;

  function automatic logic [5:0] dut_out();
    return {press_p, release_p, click_p, long_p, rpt_p, held};
  endfunction

  task automatic chk(input string name, input logic [5:0] got,
                     input logic [5:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (press,rel,click,long,rpt,held)",
               name, got, exp);
    end
  endtask

  // Reference: events derived from hold length and edges since last long/rpt.
  task automatic model(input bit b, input bit re, input bit rs);
    bit p, r, c, l, q;
    p = 0; r = 0; c = 0; l = 0; q = 0;
    if (!rs) begin
      armed = 0;
      pressed = 0;
    end else if (!armed) begin
      if (!b) armed = 1;
    end else if (!pressed) begin
      if (b) begin
        pressed = 1;
        hold_len = 1;
        long_done = 0;
        p = 1;
      end
    end else if (!b) begin
      pressed = 0;
      r = 1;
      c = !long_done;
    end else begin
      hold_len++;
      if (!long_done) begin
        if (hold_len == LONG) begin
          l = 1;
          long_done = 1;
          since = 0;
        end
      end else begin
        since++;
        if (since >= RPT && re) begin
          q = 1;
          since = 0;
        end
      end
    end
    expq.push_back({p, r, c, l, q, pressed});
  endtask

  task automatic step(input bit b, input bit re, input bit rs);
    logic prev;
    @(negedge clk);
    prev = rst_n;
    rst_n = rs;
    btn = b;
    repeat_en = re;
    if (prev === 1'b1 && !rs) begin
      #1;
      chk("async_rst", dut_out(), 6'b0);
    end
    model(b, re, rs);
  endtask

  task automatic hold(input int n, input bit re);
    for (int i = 0; i < n; i++) step(1, re, 1);
  endtask

  initial begin
    logic [5:0] e;
    forever begin
      @(posedge clk);
      #1;
      edge_no++;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk($sformatf("edge%0d", edge_no), dut_out(), e);
      end
    end
  end

  initial begin
    bit re;
    int hl, ll;
    rst_n = 1'b0;
    btn = 1'b0;
    repeat_en = 1'b0;
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 1, 1);
    step(0, 1, 1);

    hold(3, 1);
    step(0, 1, 1);
    step(0, 1, 1);

    hold(20, 1);
    step(0, 1, 1);
    step(0, 1, 1);

    hold(15, 0);
    hold(3, 1);
    step(0, 1, 1);

    hold(7, 1);
    step(0, 1, 1);

    hold(10, 1);
    step(1, 1, 0);
    step(1, 1, 0);
    hold(4, 1);
    step(0, 1, 1);
    step(1, 1, 1);
    step(0, 1, 1);

    step(1, 1, 1);
    step(0, 1, 1);
    step(1, 1, 1);
    step(0, 1, 1);

    re = 1;
    for (int s = 0; s < 40; s++) begin
      hl = int'($urandom_range(1, 25));
      for (int i = 0; i < hl; i++) begin
        if ($urandom_range(0, 7) == 0) re = !re;
        step(1, re, 1);
      end
      if ($urandom_range(0, 14) == 0) begin
        step(1, re, 0);
        step(0, re, 0);
      end
      ll = int'($urandom_range(1, 3));
      for (int i = 0; i < ll; i++) step(0, re, 1);
    end

    for (int i = 0; i < 5 && expq.size() > 0; i++) @(posedge clk);
    #2;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
